// File: rtl/pc_ras_unit.sv
// Fetch-stage program counter with redirect/advance priority and a circular
// return-address stack that predicts JR $31 targets from earlier JAL pushes.
module pc_ras_unit #(
    parameter int                WORD_W    = 32,
    parameter logic [WORD_W-1:0] PC_INIT   = 32'h0000_0000,
    parameter int                PC_STEP   = 4,
    parameter int                RAS_DEPTH = 4
) (
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic                           ihit,
    input  logic                           enable_pc,
    input  logic                           redirect,
    input  logic [WORD_W-1:0]              redirect_pc,
    input  logic                           ras_clear,
    input  logic                           fetch_call,
    input  logic                           fetch_ret,
    input  logic [WORD_W-1:0]              fetch_target,
    output logic [WORD_W-1:0]              imemaddr,
    output logic [WORD_W-1:0]              npc,
    output logic                           pred_ret,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_ovf
);

    localparam int                PTR_W      = $clog2(RAS_DEPTH);
    localparam int                CNT_W      = PTR_W + 1;
    localparam logic [WORD_W-1:0] STEP       = WORD_W'(PC_STEP);
    localparam logic [WORD_W-1:0] ALIGN_MASK = ~(STEP - WORD_W'(1));
    localparam logic [CNT_W-1:0]  RAS_FULL   = CNT_W'(RAS_DEPTH);

    function automatic logic [WORD_W-1:0] align_addr(input logic [WORD_W-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

    logic [WORD_W-1:0] pc_reg;
    logic [WORD_W-1:0] pc_next;
    logic [PTR_W-1:0]  top_ptr;
    logic [PTR_W-1:0]  push_ptr;
    logic [CNT_W-1:0]  count_reg;
    logic              ovf_reg;
    logic [WORD_W-1:0] ras_mem [RAS_DEPTH];

    logic adv;
    logic ras_empty;
    logic ras_full;
    logic do_push;
    logic do_pop;

    assign adv       = ihit & enable_pc;
    assign ras_empty = (count_reg == '0);
    assign ras_full  = (count_reg == RAS_FULL);
    assign do_push   = ~redirect & adv & fetch_call;
    assign do_pop    = ~redirect & adv & ~fetch_call & fetch_ret & ~ras_empty;
    assign push_ptr  = top_ptr + PTR_W'(1);

    assign imemaddr  = pc_reg;
    assign npc       = pc_reg + STEP;
    assign pred_ret  = do_pop;
    assign ras_count = count_reg;
    assign ras_ovf   = ovf_reg;

    always_comb begin
        pc_next = pc_reg;
        if (redirect) begin
            pc_next = align_addr(redirect_pc);
        end else if (adv) begin
            if (fetch_call) begin
                pc_next = align_addr(fetch_target);
            end else if (do_pop) begin
                pc_next = align_addr(ras_mem[top_ptr]);
            end else begin
                pc_next = npc;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_reg <= PC_INIT;
        end else begin
            pc_reg <= pc_next;
        end
    end

    // ras_clear overrides a same-cycle push/pop: the stack ends empty.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            top_ptr   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (ras_clear) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (do_push) begin
            top_ptr <= push_ptr;
            if (ras_full) begin
                ovf_reg <= 1'b1;
            end else begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end else if (do_pop) begin
            top_ptr   <= top_ptr - PTR_W'(1);
            count_reg <= count_reg - CNT_W'(1);
        end
    end

    // Entry storage carries no reset; a push when full lands on the oldest slot.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            ras_mem[push_ptr] <= npc;
        end
    end

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed self-checking bench for pc_ras_unit (default parameters, PC_INIT=0).
module tb_pc_ras_unit;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic        enable_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ras_clear;
    logic        fetch_call;
    logic        fetch_ret;
    logic [31:0] fetch_target;
    logic [31:0] imemaddr;
    logic [31:0] npc;
    logic        pred_ret;
    logic [2:0]  ras_count;
    logic        ras_ovf;

    int total = 0;
    int bad   = 0;

    pc_ras_unit #(
        .WORD_W   (32),
        .PC_INIT  (32'h0000_0000),
        .PC_STEP  (4),
        .RAS_DEPTH(4)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .enable_pc   (enable_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ras_clear   (ras_clear),
        .fetch_call  (fetch_call),
        .fetch_ret   (fetch_ret),
        .fetch_target(fetch_target),
        .imemaddr    (imemaddr),
        .npc         (npc),
        .pred_ret    (pred_ret),
        .ras_count   (ras_count),
        .ras_ovf     (ras_ovf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t limit=%0d", $time, 200000);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ihit = 0; enable_pc = 0; redirect = 0; redirect_pc = 0;
        ras_clear = 0; fetch_call = 0; fetch_ret = 0; fetch_target = 0;
    endtask

    task automatic jump(input logic [31:0] addr);
        idle();
        redirect = 1; redirect_pc = addr;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        nRST = 0;
        #12;
        total++; if (imemaddr !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want %h", imemaddr, 32'h0); end
        total++; if (npc !== 32'h4) begin bad++; $display("FAIL reset_npc: got %h want %h", npc, 32'h4); end
        total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", ras_count); end
        total++; if (ras_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ras_ovf); end
        @(negedge CLK);
        nRST = 1;
        step();
    endtask

    task automatic test_advance_hold();
        logic [31:0] exp_pc [3] = '{32'h4, 32'h8, 32'hC};
        ihit = 1; enable_pc = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (imemaddr !== exp_pc[i]) begin bad++; $display("FAIL advance%0d: got %h want %h", i, imemaddr, exp_pc[i]); end
        end
        enable_pc = 0;
        step(); step();
        total++; if (imemaddr !== 32'hC) begin bad++; $display("FAIL hold_en: got %h want %h", imemaddr, 32'hC); end
        total++; if (npc !== 32'h10) begin bad++; $display("FAIL hold_npc: got %h want %h", npc, 32'h10); end
        ihit = 0; enable_pc = 1;
        step();
        total++; if (imemaddr !== 32'hC) begin bad++; $display("FAIL hold_ihit: got %h want %h", imemaddr, 32'hC); end
        idle();
    endtask

    task automatic test_redirect();
        jump(32'h40);
        total++; if (imemaddr !== 32'h40) begin bad++; $display("FAIL redir_setup: got %h want %h", imemaddr, 32'h40); end
        redirect = 1; redirect_pc = 32'h203;
        step();
        total++; if (imemaddr !== 32'h200) begin bad++; $display("FAIL redir_align: got %h want %h", imemaddr, 32'h200); end
        total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL redir_count: got %0d want 0", ras_count); end
        // redirect beats an advancing call: no push
        redirect = 1; redirect_pc = 32'h100; ihit = 1; enable_pc = 1; fetch_call = 1; fetch_target = 32'h999;
        #1;
        total++; if (pred_ret !== 1'b0) begin bad++; $display("FAIL redir_pred: got %b want 0", pred_ret); end
        step();
        total++; if (imemaddr !== 32'h100) begin bad++; $display("FAIL redir_over_call: got %h want %h", imemaddr, 32'h100); end
        total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL redir_no_push: got %0d want 0", ras_count); end
        idle();
    endtask

    task automatic test_call_ret();
        ihit = 1; enable_pc = 1; fetch_call = 1; fetch_target = 32'h400;
        step();
        total++; if (imemaddr !== 32'h400) begin bad++; $display("FAIL call_pc: got %h want %h", imemaddr, 32'h400); end
        total++; if (ras_count !== 3'd1) begin bad++; $display("FAIL call_count: got %0d want 1", ras_count); end
        fetch_call = 0;
        step();
        fetch_ret = 1;
        #1;
        total++; if (pred_ret !== 1'b1) begin bad++; $display("FAIL ret_pred: got %b want 1", pred_ret); end
        step();
        total++; if (imemaddr !== 32'h104) begin bad++; $display("FAIL ret_pc: got %h want %h", imemaddr, 32'h104); end
        total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL ret_count: got %0d want 0", ras_count); end
        idle();
    endtask

    task automatic test_overflow();
        logic [31:0] ret_pc [4] = '{32'h54, 32'h44, 32'h34, 32'h24};
        jump(32'h10);
        ihit = 1; enable_pc = 1; fetch_call = 1;
        for (int i = 0; i < 5; i++) begin
            fetch_target = 32'h20 + 32'(i) * 32'h10;
            step();
        end
        total++; if (imemaddr !== 32'h60) begin bad++; $display("FAIL ovf_pc: got %h want %h", imemaddr, 32'h60); end
        total++; if (ras_count !== 3'd4) begin bad++; $display("FAIL ovf_count: got %0d want 4", ras_count); end
        total++; if (ras_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", ras_ovf); end
        fetch_call = 0; fetch_ret = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (pred_ret !== 1'b1) begin bad++; $display("FAIL ovf_pred%0d: got %b want 1", i, pred_ret); end
            step();
            total++; if (imemaddr !== ret_pc[i]) begin bad++; $display("FAIL ovf_ret%0d: got %h want %h", i, imemaddr, ret_pc[i]); end
        end
        #1;
        total++; if (pred_ret !== 1'b0) begin bad++; $display("FAIL ovf_empty_pred: got %b want 0", pred_ret); end
        step();
        total++; if (imemaddr !== 32'h28) begin bad++; $display("FAIL ovf_empty_pc: got %h want %h", imemaddr, 32'h28); end
        total++; if (ras_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", ras_ovf); end
        idle();
    endtask

    task automatic test_empty_ret_call_ret();
        ras_clear = 1;
        step();
        total++; if (ras_ovf !== 1'b0) begin bad++; $display("FAIL clear_ovf: got %b want 0", ras_ovf); end
        jump(32'h80);
        ihit = 1; enable_pc = 1; fetch_ret = 1;
        #1;
        total++; if (pred_ret !== 1'b0) begin bad++; $display("FAIL empty_pred: got %b want 0", pred_ret); end
        step();
        total++; if (imemaddr !== 32'h84) begin bad++; $display("FAIL empty_ret: got %h want %h", imemaddr, 32'h84); end
        jump(32'h90);
        ihit = 1; enable_pc = 1; fetch_call = 1; fetch_ret = 1; fetch_target = 32'h300;
        #1;
        total++; if (pred_ret !== 1'b0) begin bad++; $display("FAIL callret_pred: got %b want 0", pred_ret); end
        step();
        total++; if (imemaddr !== 32'h300) begin bad++; $display("FAIL callret_pc: got %h want %h", imemaddr, 32'h300); end
        total++; if (ras_count !== 3'd1) begin bad++; $display("FAIL callret_count: got %0d want 1", ras_count); end
        fetch_call = 0;
        step();
        total++; if (imemaddr !== 32'h94) begin bad++; $display("FAIL callret_pop: got %h want %h", imemaddr, 32'h94); end
        idle();
    endtask

    task automatic test_clear_wrap();
        ihit = 1; enable_pc = 1; fetch_call = 1;
        for (int i = 0; i < 5; i++) begin
            fetch_target = 32'h500 + 32'(i) * 32'h10;
            step();
        end
        total++; if (ras_ovf !== 1'b1) begin bad++; $display("FAIL clr_setup_ovf: got %b want 1", ras_ovf); end
        ras_clear = 1; fetch_target = 32'h603;
        step();
        total++; if (imemaddr !== 32'h600) begin bad++; $display("FAIL clr_pc: got %h want %h", imemaddr, 32'h600); end
        total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL clr_count: got %0d want 0", ras_count); end
        total++; if (ras_ovf !== 1'b0) begin bad++; $display("FAIL clr_ovf: got %b want 0", ras_ovf); end
        ras_clear = 0; fetch_call = 0; fetch_ret = 1;
        step();
        total++; if (imemaddr !== 32'h604) begin bad++; $display("FAIL clr_ret: got %h want %h", imemaddr, 32'h604); end
        jump(32'hFFFF_FFFC);
        total++; if (npc !== 32'h0) begin bad++; $display("FAIL wrap_npc: got %h want %h", npc, 32'h0); end
        ihit = 1; enable_pc = 1;
        step();
        total++; if (imemaddr !== 32'h0) begin bad++; $display("FAIL wrap_pc: got %h want %h", imemaddr, 32'h0); end
        idle();
    endtask

    task automatic test_async_reset();
        jump(32'h700);
        ihit = 1; enable_pc = 1; fetch_call = 1; fetch_target = 32'h800;
        step();
        total++; if (ras_count !== 3'd1) begin bad++; $display("FAIL areset_setup: got %0d want 1", ras_count); end
        fetch_call = 0;
        #2;
        nRST = 0;
        #1;
        total++; if (imemaddr !== 32'h0) begin bad++; $display("FAIL areset_pc: got %h want %h", imemaddr, 32'h0); end
        total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL areset_count: got %0d want 0", ras_count); end
        @(negedge CLK);
        nRST = 1;
        step();
        total++; if (imemaddr !== 32'h4) begin bad++; $display("FAIL areset_resume: got %h want %h", imemaddr, 32'h4); end
        idle();
    endtask

    initial begin
        nRST = 0;
        idle();
        test_reset();
        test_advance_hold();
        test_redirect();
        test_call_ret();
        test_overflow();
        test_empty_ret_call_ret();
        test_clear_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
- Parametrised next-generation program counter for the fetch stage.
- Holds the fetch address and applies the advance and redirect priority rules.
- Predicts subroutine returns with an internal circular return-address stack (RAS).
- Sits between fetch and the instruction memory port; redirects come from the branch/jump resolution stage.

Parameters:
- WORD_W, 32, width of all addresses.
- PC_INIT, 32'h0000_0000, fetch address after reset.
- PC_STEP, 4, sequential increment; power of two; the low log2(PC_STEP) address bits are forced to 0.
- RAS_DEPTH, 4, number of return-stack entries; power of two, at least 2.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  reset; asynchronous, active-low.
- ihit  input  1  instruction memory returned the word at imemaddr this cycle.
- enable_pc  input  1  pipeline permits fetch to advance (no hazard stall).
- redirect  input  1  resolved control-flow change; highest priority.
- redirect_pc  input  WORD_W  target when redirect=1.
- ras_clear  input  1  empties the RAS and clears ras_ovf.
- fetch_call  input  1  word at imemaddr is a JAL.
- fetch_ret  input  1  word at imemaddr is JR $31.
- fetch_target  input  WORD_W  JAL target computed in fetch.
- imemaddr  output  WORD_W  current fetch address (registered).
- npc  output  WORD_W  imemaddr + PC_STEP (combinational).
- pred_ret  output  1  this cycle's update uses the RAS top (combinational).
- ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_ovf  output  1  sticky: a push overwrote the oldest entry.

Behaviour:
- Reset (nRST=0, asynchronous): imemaddr=PC_INIT, ras_count=0, ras_ovf=0, top pointer=0. RAS entry contents are don't-care.
- Define adv = ihit & enable_pc. One registered update per rising edge, applied in this priority order:
  1. redirect=1: imemaddr <= aligned redirect_pc, regardless of ihit or enable_pc. No RAS push or pop. If ras_clear=1 in the same cycle, the clear is also applied.
  2. adv=0: imemaddr holds. RAS unchanged, apart from ras_clear.
  3. adv & fetch_call: push npc onto the RAS, then imemaddr <= aligned fetch_target. If fetch_ret is also 1 it is ignored (call wins).
  4. adv & fetch_ret & ras_count!=0: imemaddr <= top entry, pop. pred_ret=1.
  5. adv & fetch_ret & ras_count==0: imemaddr <= npc. pred_ret=0, no pop.
  6. Otherwise adv: imemaddr <= npc.
- pred_ret = ~redirect & adv & ~fetch_call & fetch_ret & (ras_count!=0).
- Alignment: every loaded target has its low log2(PC_STEP) bits forced to 0. Address arithmetic wraps modulo 2^WORD_W with no carry out (e.g. 32'hFFFF_FFFC + 4 = 32'h0).
- RAS storage:
  - Circular buffer of RAS_DEPTH entries with a top pointer that wraps modulo RAS_DEPTH.
  - Push writes to (top+1) mod RAS_DEPTH and advances top.
  - Pop reads entry[top] and retreats top.
  - ras_count saturates at RAS_DEPTH. A push when full overwrites the oldest entry and sets ras_ovf, which stays set until ras_clear or reset.
  - A pop when empty never occurs (rule 5).
- ras_clear without redirect: count=0 and ras_ovf=0 on that edge. ras_clear has priority over a push or pop in the same cycle: the PC update still happens, the RAS ends empty.
- Reset asserted mid-operation returns all state to reset values immediately. First update after release uses PC_INIT as the base.
- Outputs never depend combinationally on redirect_pc or fetch_target; only pred_ret depends on control inputs.

Test Plan:
- Reset then hold: PC_INIT=0. Pulse ihit=1, enable_pc=1 for 3 cycles, then enable_pc=0 with ihit=1 -> imemaddr 0, 4, 8, 12, then holds 12; npc=16.
- Redirect priority: imemaddr=0x40, ihit=0, redirect=1, redirect_pc=0x203 -> imemaddr=0x200 next cycle; ras_count unchanged.
- Call/return prediction: at 0x100 fetch_call=1, fetch_target=0x400 -> imemaddr=0x400, ras_count=1. At 0x404 fetch_ret=1 -> pred_ret=1, imemaddr=0x104, ras_count=0.
- Overflow: RAS_DEPTH=4, five calls from 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_count=4, ras_ovf=1. Returns yield 0x54, 0x44, 0x34, 0x24; a fifth return has pred_ret=0 and gives npc.
- Empty return and simultaneous call+ret: fetch_ret with ras_count=0 at 0x80 -> imemaddr=0x84. fetch_call=fetch_ret=1 at 0x90, target 0x300 -> imemaddr=0x300, push 0x94.
- Clear and wrap: ras_clear with a pending call -> PC=target, ras_count=0, ras_ovf=0. imemaddr=0xFFFF_FFFC advancing -> 0x0000_0000. nRST pulsed low mid-stream -> imemaddr=PC_INIT asynchronously.
